// File: rtl/ac97_dma_sched.sv
// AC97 DMA scheduler: arbitrates one Wishbone master between playback reads and record writes,
// with an 8-word sample FIFO per direction. Define AC97_DMA_XRUN_EN for sticky under/overrun flags.
module ac97_dma_sched #(
  parameter int FIFO_AW = 3
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        dmar_en,
  input  logic [29:0] dmar_addr,
  input  logic [15:0] dmar_remaining,
  output logic        dmar_next,
  input  logic        dmaw_en,
  input  logic [29:0] dmaw_addr,
  input  logic [15:0] dmaw_remaining,
  output logic        dmaw_next,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  output logic [3:0]  wbm_sel_o,
  output logic        wbm_we_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  input  logic        wbm_ack_i,
  input  logic        down_pop,
  output logic [31:0] down_sample,
  output logic        down_valid,
  input  logic        up_push,
  input  logic [31:0] up_sample,
  input  logic        xrun_clr,
  output logic        down_underrun,
  output logic        up_overrun
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] C_FULL = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  state_t             r_state;
  state_t             w_nextState;
  logic               r_cyc;
  logic               r_we;
  logic [31:0]        r_adr;
  logic               r_lastWr;
  logic               r_dmarNext;
  logic               r_dmawNext;

  logic [31:0]        r_pbMem [DEPTH];
  logic [FIFO_AW:0]   r_pbWptr;
  logic [FIFO_AW:0]   r_pbRptr;
  logic [31:0]        r_recMem [DEPTH];
  logic [FIFO_AW:0]   r_recWptr;
  logic [FIFO_AW:0]   r_recRptr;

  logic [FIFO_AW:0]   w_pbLevel;
  logic [FIFO_AW:0]   w_recLevel;
  logic               w_pbEmpty;
  logic               w_recEmpty;
  logic               w_recFull;
  logic               w_rdReq;
  logic               w_wrReq;
  logic               w_grantRd;
  logic               w_grantWr;
  logic               w_ackRd;
  logic               w_ackWr;
  logic               w_pbPop;
  logic               w_recPush;
  logic [31:0]        w_pbHead;
  logic [31:0]        w_recHead;

  assign w_pbLevel  = r_pbWptr - r_pbRptr;
  assign w_recLevel = r_recWptr - r_recRptr;
  assign w_pbEmpty  = (r_pbWptr == r_pbRptr);
  assign w_recEmpty = (r_recWptr == r_recRptr);
  assign w_recFull  = (w_recLevel == C_FULL);

  assign w_rdReq = dmar_en & (dmar_remaining != '0) & (w_pbLevel != C_FULL);
  assign w_wrReq = dmaw_en & (dmaw_remaining != '0) & ~w_recEmpty;

  // A next pulse blocks granting so the control interface can advance address/count first.
  always_comb begin
    w_nextState = r_state;
    w_grantRd   = 1'b0;
    w_grantWr   = 1'b0;
    w_ackRd     = 1'b0;
    w_ackWr     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!(r_dmarNext | r_dmawNext)) begin
          if (w_rdReq && (!w_wrReq || r_lastWr)) begin
            w_grantRd   = 1'b1;
            w_nextState = S_READ;
          end else if (w_wrReq) begin
            w_grantWr   = 1'b1;
            w_nextState = S_WRITE;
          end
        end
      end
      S_READ: begin
        if (wbm_ack_i) begin
          w_ackRd     = 1'b1;
          w_nextState = S_IDLE;
        end
      end
      S_WRITE: begin
        if (wbm_ack_i) begin
          w_ackWr     = 1'b1;
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= S_IDLE;
      r_cyc      <= 1'b0;
      r_we       <= 1'b0;
      r_adr      <= '0;
      r_lastWr   <= 1'b1;
      r_dmarNext <= 1'b0;
      r_dmawNext <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_dmarNext <= w_ackRd;
      r_dmawNext <= w_ackWr;
      if (w_grantRd) begin
        r_cyc    <= 1'b1;
        r_we     <= 1'b0;
        r_adr    <= {dmar_addr, 2'b00};
        r_lastWr <= 1'b0;
      end else if (w_grantWr) begin
        r_cyc    <= 1'b1;
        r_we     <= 1'b1;
        r_adr    <= {dmaw_addr, 2'b00};
        r_lastWr <= 1'b1;
      end else if (w_ackRd || w_ackWr) begin
        r_cyc <= 1'b0;
        r_we  <= 1'b0;
      end
    end
  end

  assign w_pbPop   = down_pop & ~w_pbEmpty;
  assign w_recPush = up_push & ~w_recFull;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pbWptr  <= '0;
      r_pbRptr  <= '0;
      r_recWptr <= '0;
      r_recRptr <= '0;
    end else begin
      if (w_ackRd)   r_pbWptr  <= r_pbWptr + 1'b1;
      if (w_pbPop)   r_pbRptr  <= r_pbRptr + 1'b1;
      if (w_recPush) r_recWptr <= r_recWptr + 1'b1;
      if (w_ackWr)   r_recRptr <= r_recRptr + 1'b1;
    end
  end

  // Storage is not reset; heads are masked to zero whenever their FIFO is empty or idle.
  always_ff @(posedge sys_clk) begin
    if (w_ackRd)   r_pbMem[r_pbWptr[FIFO_AW-1:0]]   <= wbm_dat_i;
    if (w_recPush) r_recMem[r_recWptr[FIFO_AW-1:0]] <= up_sample;
  end

  assign w_pbHead  = r_pbMem[r_pbRptr[FIFO_AW-1:0]];
  assign w_recHead = r_recMem[r_recRptr[FIFO_AW-1:0]];

  assign down_valid  = ~w_pbEmpty;
  assign down_sample = w_pbEmpty ? 32'd0 : w_pbHead;

  assign wbm_adr_o = r_adr;
  assign wbm_dat_o = (r_state == S_WRITE) ? w_recHead : 32'd0;
  assign wbm_sel_o = 4'hf;
  assign wbm_we_o  = r_we;
  assign wbm_cyc_o = r_cyc;
  assign wbm_stb_o = r_cyc;
  assign dmar_next = r_dmarNext;
  assign dmaw_next = r_dmawNext;

`ifdef AC97_DMA_XRUN_EN
  logic r_underrun;
  logic r_overrun;

  // Setting wins over clearing so an xrun in the clear cycle is never lost.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_underrun <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (down_pop && w_pbEmpty) r_underrun <= 1'b1;
      else if (xrun_clr)         r_underrun <= 1'b0;
      if (up_push && w_recFull)  r_overrun  <= 1'b1;
      else if (xrun_clr)         r_overrun  <= 1'b0;
    end
  end

  assign down_underrun = r_underrun;
  assign up_overrun    = r_overrun;
`else
  logic w_unusedXrunClr;
  assign w_unusedXrunClr = xrun_clr;
  assign down_underrun   = 1'b0;
  assign up_overrun      = 1'b0;
`endif

endmodule
